// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver. The line inputs are synchronised and the clock
// is deglitched. 11-bit frames are deframed and checked, and the accepted
// bytes, or key events in decoded mode, are buffered in a FIFO for the CPU.
module ps2_rx_fifo #(
  parameter int unsigned AW         = 3,
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned TIMEOUT    = 50000,
  parameter int unsigned RAW_MODE   = 1
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  input  logic          rdn,
  input  logic          clr_err,
  output logic [9:0]    data,
  output logic          ready,
  output logic          overflow,
  output logic          parity_err,
  output logic          frame_err,
  output logic [AW:0]   level
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned FW    = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW    = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] WD_MAX   = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk, filt_prev;
  logic [FW-1:0] filt_cnt;
  logic          strobe;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic          ext_pend, brk_pend;
  logic [TW-1:0] wd_cnt;
  logic          timeout;
  logic          frame_done, frame_bad, par_bad, byte_ok;
  logic [7:0]    rx_byte;
  logic          push_req;
  logic [9:0]    push_data;
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] w_ptr, r_ptr;
  logic          pop, push_ok;

  // Two-flop synchronisers for both PS/2 lines
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Stability filter: the filtered clock follows only after FILTER_LEN stable cycles
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_MAX) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign strobe  = filt_prev & ~filt_clk;
  assign timeout = (bit_cnt != 4'd0) && !strobe && (wd_cnt == WD_MAX);

  // Frame checks run at the stop-bit strobe; the stop bit is the live data bit
  always_comb begin
    rx_byte    = shreg[8:1];
    frame_done = strobe && (bit_cnt == 4'd10);
    frame_bad  = frame_done && (shreg[0] || !dat_s2);
    par_bad    = frame_done && !frame_bad && !(^shreg[9:1]);
    byte_ok    = frame_done && !frame_bad && !par_bad;
    if (RAW_MODE != 0) begin
      push_req  = byte_ok;
      push_data = {2'b00, rx_byte};
    end else begin
      push_req  = byte_ok && (rx_byte != 8'hE0) && (rx_byte != 8'hF0);
      push_data = {ext_pend, brk_pend, rx_byte};
    end
  end

  // Deframer bit counter, shift register and prefix tracking
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (timeout) begin
      bit_cnt  <= '0;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (strobe) begin
      if (bit_cnt == 4'd10) begin
        bit_cnt <= '0;
      end else begin
        shreg[bit_cnt] <= dat_s2;
        bit_cnt        <= bit_cnt + 1'b1;
      end
      if (byte_ok && (RAW_MODE == 0)) begin
        if (rx_byte == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (rx_byte == 8'hF0) begin
          brk_pend <= 1'b1;
        end else begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end
      end
    end
  end

  // Watchdog: counts idle cycles only while a frame is partially received
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wd_cnt <= '0;
    end else if (bit_cnt == 4'd0 || strobe || timeout) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Sticky error flags; a new error beats a simultaneous clear
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      parity_err <= (parity_err && !clr_err) || par_bad;
      frame_err  <= (frame_err && !clr_err) || frame_bad || timeout;
    end
  end

  assign ready   = (level != '0);
  assign pop     = !rdn && ready;
  assign push_ok = push_req && ((level != FULL_LVL) || pop);
  assign data    = mem[r_ptr];

  // FIFO storage, pointers, fill level and overflow flag
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      w_ptr    <= '0;
      r_ptr    <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[w_ptr] <= push_data;
        w_ptr      <= w_ptr + 1'b1;
      end
      if (pop) begin
        r_ptr    <= r_ptr + 1'b1;
        overflow <= 1'b0;
      end else if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end
      if (push_ok && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push_ok) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench: a raw-mode 4-entry instance and a decoded-mode 8-entry
// instance listen to the same PS/2 lines and are checked against hand values.
module tb_ps2_rx_fifo;

  localparam int H  = 10;   // clk cycles per PS/2 clock half period
  localparam int TO = 400;  // watchdog timeout used by both instances

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rdn_r = 1'b1, rdn_d = 1'b1;
  logic       clr_err = 1'b0;

  logic [9:0] data_r, data_d;
  logic       ready_r, ready_d, ovf_r, ovf_d, perr_r, perr_d, ferr_r, ferr_d;
  logic [2:0] level_r;
  logic [3:0] level_d;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ps2_rx_fifo #(.AW(2), .FILTER_LEN(4), .TIMEOUT(TO), .RAW_MODE(1)) u_raw (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rdn(rdn_r),
    .clr_err(clr_err), .data(data_r), .ready(ready_r), .overflow(ovf_r),
    .parity_err(perr_r), .frame_err(ferr_r), .level(level_r)
  );

  ps2_rx_fifo #(.AW(3), .FILTER_LEN(4), .TIMEOUT(TO), .RAW_MODE(0)) u_dec (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rdn(rdn_d),
    .clr_err(clr_err), .data(data_d), .ready(ready_d), .overflow(ovf_d),
    .parity_err(perr_d), .frame_err(ferr_d), .level(level_d)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send the first n bits of an 11-bit frame, LSB (start) first
  task automatic send_bits(input logic [10:0] fr, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) ps2_data = fr[i];
      if (glitch) begin
        repeat (3) @(negedge clk);
        ps2_clk = 1'b0;
        @(negedge clk) ps2_clk = 1'b1;
        repeat (H - 4) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      ps2_clk = 1'b0;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit glitch);
    logic par;
    par = ~(^b) ^ bad_par;
    send_bits({1'b1, par, b, 1'b0}, 11, glitch);
    ps2_data = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic pop_both(input bit r, input bit d);
    @(negedge clk);
    rdn_r = ~r;
    rdn_d = ~d;
    @(negedge clk);
    rdn_r = 1'b1;
    rdn_d = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk) clrn = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", ready_r, 0);
    chk("rst_level", level_r, 0);
    chk("rst_data", data_r, 0);
    chk("rst_flags", {ovf_r, perr_r, ferr_r}, 0);
    clrn = 1'b1;
    repeat (3) @(negedge clk);

    // 1: raw single byte, then pop
    send_byte(8'h1C, 0, 0);
    chk("t1_ready", ready_r, 1);
    chk("t1_data", data_r, 10'h01C);
    chk("t1_level", level_r, 1);
    pop_both(1, 1);
    chk("t1_pop_ready", ready_r, 0);
    chk("t1_pop_level", level_r, 0);

    // 2: decoded E0 F0 75 folds into one event
    send_byte(8'hE0, 0, 0);
    send_byte(8'hF0, 0, 0);
    chk("t2_no_prefix_push", level_d, 0);
    send_byte(8'h75, 0, 0);
    chk("t2_level", level_d, 1);
    chk("t2_data", data_d, 10'h375);
    chk("t2_raw_level", level_r, 3);
    send_byte(8'h1C, 0, 0);
    pop_both(0, 1);
    chk("t2_next_data", data_d, 10'h01C);
    chk("t2_next_level", level_d, 1);
    chk("t2_raw_full", level_r, 4);

    // 3: parity error is sticky, does not block reception, clears on clr_err
    do_reset();
    send_byte(8'h1C, 1, 0);
    chk("t3_perr", perr_r, 1);
    chk("t3_perr_dec", perr_d, 1);
    chk("t3_level", level_r, 0);
    send_byte(8'h1C, 0, 0);
    chk("t3_level2", level_r, 1);
    chk("t3_data2", data_r, 10'h01C);
    chk("t3_perr_hold", perr_r, 1);
    @(negedge clk) clr_err = 1'b1;
    @(negedge clk) clr_err = 1'b0;
    chk("t3_perr_clr", perr_r, 0);
    chk("t3_ferr", ferr_r, 0);

    // 4: overflow on the 4-deep instance
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i), 0, 0);
    chk("t4_level", level_r, 4);
    chk("t4_ovf", ovf_r, 1);
    chk("t4_head", data_r, 10'h011);
    chk("t4_dec_level", level_d, 5);
    chk("t4_dec_ovf", ovf_d, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t4_pop_data", data_r, 10'h011 + 10'(i));
      pop_both(1, 0);
      if (i == 0) chk("t4_ovf_clr", ovf_r, 0);
    end
    chk("t4_empty", ready_r, 0);

    // 5: watchdog discards a partial frame
    do_reset();
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 6, 0);
    ps2_data = 1'b1;
    repeat (TO + 10) @(negedge clk);
    chk("t5_ferr", ferr_r, 1);
    chk("t5_ferr_dec", ferr_d, 1);
    chk("t5_level", level_r, 0);
    send_byte(8'h1C, 0, 0);
    chk("t5_level2", level_r, 1);
    chk("t5_data", data_r, 10'h01C);
    chk("t5_perr", perr_r, 0);

    // 6: short clock glitches are filtered; reset mid-frame discards it
    do_reset();
    send_byte(8'h1C, 0, 1);
    chk("t6_glitch_data", data_r, 10'h01C);
    chk("t6_glitch_level", level_r, 1);
    chk("t6_glitch_flags", {perr_r, ferr_r}, 0);
    send_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 5, 0);
    @(negedge clk) clrn = 1'b0;
    #1;
    chk("t6_rst_ready", ready_r, 0);
    chk("t6_rst_level", level_r, 0);
    chk("t6_rst_data", data_r, 0);
    @(negedge clk) clrn = 1'b1;
    ps2_data = 1'b1;
    repeat (2 * H) @(negedge clk);
    send_byte(8'h1C, 0, 0);
    chk("t6_after_data", data_r, 10'h01C);
    chk("t6_after_level", level_r, 1);
    chk("t6_after_ferr", ferr_r, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
